fcmp_stage: RTL
===============

Name: fcmp_stage

Overview:
- Pipelined FPU compare stage for feq/flt/fle.
- Sits between the FPU operand-read/issue stage and the integer writeback port.
- Accepts one compare per cycle under a valid/ready handshake and returns a 32-bit 0/1 result tagged with its destination register.
- Compare semantics match the team's existing combinational fle: sign-magnitude-to-ordered-key transform, with zero-exponent operands flushed to +0.

Parameters:
- TAG_W, 5, width of destination-register tag carried alongside the operation.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  stage can accept request this cycle
- in_op  in  2  00=feq, 01=flt, 10=fle, 11=reserved
- in_tag  in  TAG_W  destination tag
- x1  in  32  IEEE-754 single operand A
- x2  in  32  IEEE-754 single operand B
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_tag  out  TAG_W  tag of result
- y  out  32  result, 32'd1 if relation true else 32'd0
- out_illegal  out  1  op was 11; y forced 0

Behaviour:
- Reset (rst=1 at clk edge): S1 and S2 valid bits cleared; out_valid=0, y=0, out_tag=0, out_illegal=0. in_ready=1 from the first cycle after reset. Requests presented during reset are dropped.
- Key transform per operand (combinational, sub-module):
  - If e==0: s'=1, e'=0, m'=0. This flushes ±0 and denormals to +0.
  - Otherwise: s'=~s, e'=s' ? e : ~e, m'=s' ? m : ~m.
  - key = {s',e',m'} (32 bits, unsigned ordering).
- NaN: no special case. NaNs order by key exactly as fle does.
- Pipeline, stage S1:
  - Registers the op, the tag, and both keys.
  - Key transform is done before the S1 register.
- Pipeline, stage S2:
  - Computes eq = (k1==k2), lt = (k1<k2), le = lt|eq.
  - Selects by op and registers y, tag and illegal.
- Latency: 2 cycles from an accepted request (in_valid & in_ready) to out_valid with no backpressure. Throughput 1/cycle.
- Handshake:
  - Transfer occurs on valid&ready at the clock edge.
  - out_valid, y, out_tag and out_illegal hold stable while out_valid=1 and out_ready=0.
  - s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv. Purely combinational from out_ready; no skid buffer, no bubble insertion.
- Simultaneous accept and emit in the same cycle is legal; the pipeline stays full with no lost or duplicated entries.
- Full condition: both stages valid and out_ready=0 → in_ready=0, no state changes.
- Reset mid-operation: in-flight entries are discarded and no result is emitted afterward.
- Reserved op 11: accepted normally; result y=0, out_illegal=1.
- out_illegal=0 for ops 00/01/10.

Decomposition:
- Shared package fpu_pkg:
  - op encodings FCMP_EQ=2'b00, FCMP_LT=2'b01, FCMP_LE=2'b10
  - float field widths EXP_W=8, MAN_W=23
  - FLT_W=32
- Sub-module fcmp_key:
  - Combinational; input 32-bit float, output 32-bit ordered key.
  - Instantiated twice, ahead of the S1 register.

Test Plan:
- fle 0x3F800000 (1.0) vs 0x40000000 (2.0), out_ready=1 → y=1 two cycles after accept. flt same operands → 1. feq → 0.
- feq 0x80000000 (-0) vs 0x00000000 (+0) → y=1. Also feq 0x00000001 (denormal) vs 0x00000000 → y=1 (flush).
- flt 0xBF800000 (-1.0) vs 0x3F800000 → y=1. flt 0xC0000000 (-2.0) vs 0xBF800000 (-1.0) → y=1. fle reversed operands → y=0.
- Back-to-back stream of 6 requests with tags 1..6 and out_ready held low for cycles 3–5:
  - in_ready drops once both stages are full.
  - Outputs stay stable while stalled.
  - Results emerge in tag order 1..6 with none lost or duplicated.
- op=11, x1=x2=0x3F800000 → y=0, out_illegal=1, tag preserved.
- Two requests in flight, assert rst one cycle → out_valid=0 next cycle and stays 0; first post-reset request completes with latency 2.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: compare-op encodings and IEEE-754 single field widths.
package fpu_pkg;

  localparam int FLT_W = 32;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef enum logic [1:0] {
    FCMP_EQ  = 2'b00,
    FCMP_LT  = 2'b01,
    FCMP_LE  = 2'b10,
    FCMP_RSV = 2'b11
  } fcmp_op_t;

endpackage

// File: rtl/fcmp_key.sv
// Maps an IEEE-754 single to a 32-bit key whose unsigned order matches the
// float order. Zero-exponent inputs (+/-0 and denormals) all map to the +0 key.
//   f   : float operand
//   key : ordered key {s', e', m'}
module fcmp_key
  import fpu_pkg::*;
(
  input  logic [FLT_W-1:0] f,
  output logic [FLT_W-1:0] key
);

  logic             sgn;
  logic [EXP_W-1:0] expo;
  logic [MAN_W-1:0] man;

  assign sgn  = f[FLT_W-1];
  assign expo = f[FLT_W-2 -: EXP_W];
  assign man  = f[MAN_W-1:0];

  always_comb begin
    key = {1'b1, {(FLT_W-1){1'b0}}};
    if (expo != '0) begin
      // Negative values get exponent and mantissa inverted so that larger
      // magnitudes sort lower; positive values keep them and sit above.
      if (sgn) key = {1'b0, ~expo, ~man};
      else     key = {1'b1, expo, man};
    end
  end

endmodule

// File: rtl/fcmp_stage.sv
// Two-stage pipelined FPU compare (feq/flt/fle) with valid/ready handshake.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : request handshake; in_op, in_tag, x1, x2 are the request
//   out_valid/out_ready   : result handshake; y (0/1), out_tag, out_illegal
// S1 holds the ordered keys, S2 holds the compare result. in_ready is
// combinational from out_ready: the whole pipe advances together when the
// output side can drain, and empty stages always accept.
module fcmp_stage
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  input  logic [FLT_W-1:0] x1,
  input  logic [FLT_W-1:0] x2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [FLT_W-1:0] y,
  output logic             out_illegal
);

  logic [FLT_W-1:0] k1_d, k2_d;

  fcmp_key u_key1 (.f(x1), .key(k1_d));
  fcmp_key u_key2 (.f(x2), .key(k2_d));

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  fcmp_op_t         s1_op;
  logic [TAG_W-1:0] s1_tag;
  logic [FLT_W-1:0] s1_k1, s1_k2;

  assign s2_adv   = ~s2_valid | out_ready;
  assign s1_adv   = ~s1_valid | s2_adv;
  assign in_ready = s1_adv;

  // S1: keys, op and tag
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= FCMP_EQ;
      s1_tag   <= '0;
      s1_k1    <= '0;
      s1_k2    <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op  <= fcmp_op_t'(in_op);
        s1_tag <= in_tag;
        s1_k1  <= k1_d;
        s1_k2  <= k2_d;
      end
    end
  end

  logic             eq, lt;
  logic [FLT_W-1:0] y_d;
  logic             ill_d;

  always_comb begin
    eq    = (s1_k1 == s1_k2);
    lt    = (s1_k1 < s1_k2);
    y_d   = '0;
    ill_d = 1'b0;
    case (s1_op)
      FCMP_EQ: y_d = {{(FLT_W-1){1'b0}}, eq};
      FCMP_LT: y_d = {{(FLT_W-1){1'b0}}, lt};
      FCMP_LE: y_d = {{(FLT_W-1){1'b0}}, lt | eq};
      default: ill_d = 1'b1;
    endcase
  end

  // S2: result registers; held while stalled since they only load on s2_adv
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid    <= 1'b0;
      y           <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y           <= y_d;
        out_tag     <= s1_tag;
        out_illegal <= ill_d;
      end
    end
  end

  assign out_valid = s2_valid;

endmodule
